// File: rtl/deser_param.sv
// Serial-to-parallel collector: packs valid-qualified bits into DATA_W-bit words, MSB- or LSB-first per word.
// Latency: one edge from the completing (or flushing) bit to deser_data_val_o; two extra cycles after reset release.
// Backpressure: none on the input; an unaccepted word is overwritten by the next one and ovf_o pulses.
// Optional DESER_PARITY_EN: adds an even-parity bit after each word and the par_err_o output.
module deser_param #(
    parameter  int DATA_W = 16,
    localparam int CNT_W  = $clog2(DATA_W + 1)
) (
    input  logic              clk_i,
    input  logic              arst_n_i,
    input  logic              data_i,
    input  logic              data_val_i,
    input  logic              msb_first_i,
    input  logic              flush_i,
    input  logic              deser_ready_i,
    output logic [DATA_W-1:0] deser_data_o,
    output logic [CNT_W-1:0]  deser_len_o,
    output logic              deser_data_val_o,
    output logic              ovf_o
`ifdef DESER_PARITY_EN
    ,
    output logic              par_err_o
`endif
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_COLLECT = 2'd1;
`ifdef DESER_PARITY_EN
    localparam logic [1:0] ST_PARITY  = 2'd2;
`endif

    localparam logic [CNT_W-1:0] K_LAST = CNT_W'(DATA_W - 1);
    localparam logic [CNT_W-1:0] K_FULL = CNT_W'(DATA_W);

    logic              rst_meta;
    logic              rst_n;

    logic [1:0]        state;
    logic [1:0]        state_nxt;
    logic [CNT_W-1:0]  k;
    logic [CNT_W-1:0]  k_nxt;
    logic [CNT_W-1:0]  k_inc;
    logic [CNT_W-1:0]  pos;
    logic [DATA_W-1:0] sr;
    logic [DATA_W-1:0] sr_next;
    logic              msb_q;
    logic              msb_eff;
    logic              msb_nxt;
    logic              take_bit;
    logic              load;
    logic [CNT_W-1:0]  load_len;
`ifdef DESER_PARITY_EN
    logic              load_par;
`endif

    // Reset asserts immediately but releases only after two clean clock edges.
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            rst_meta <= 1'b0;
            rst_n    <= 1'b0;
        end else begin
            rst_meta <= 1'b1;
            rst_n    <= rst_meta;
        end
    end

    // Next-state logic: place the incoming bit, decide completion / flush / parity.
    always_comb begin
        msb_eff   = (state == ST_IDLE) ? msb_first_i : msb_q;
        msb_nxt   = (data_val_i && state == ST_IDLE) ? msb_first_i : msb_q;
        pos       = msb_eff ? (K_LAST - k) : k;
`ifdef DESER_PARITY_EN
        take_bit  = data_val_i && (state != ST_PARITY);
        load_par  = 1'b0;
`else
        take_bit  = data_val_i;
`endif
        k_inc     = k + CNT_W'(take_bit);
        sr_next   = sr;
        for (int i = 0; i < DATA_W; i++) begin
            if (take_bit && CNT_W'(i) == pos) begin
                sr_next[i] = data_i;
            end
        end
        state_nxt = state;
        k_nxt     = k;
        load      = 1'b0;
        load_len  = '0;

        case (state)
`ifdef DESER_PARITY_EN
            ST_PARITY: begin
                // Parity bit closes the word; a flush here gives up on the parity bit.
                if (data_val_i) begin
                    load     = 1'b1;
                    load_len = K_FULL;
                    load_par = (^sr) ^ data_i;
                end else if (flush_i) begin
                    load     = 1'b1;
                    load_len = K_FULL;
                    load_par = 1'b1;
                end
                if (load) begin
                    state_nxt = ST_IDLE;
                    k_nxt     = '0;
                end
            end
`endif
            default: begin
                if (take_bit && k == K_LAST) begin
`ifdef DESER_PARITY_EN
                    if (flush_i) begin
                        load      = 1'b1;
                        load_len  = K_FULL;
                        load_par  = 1'b1;
                        state_nxt = ST_IDLE;
                    end else begin
                        state_nxt = ST_PARITY;
                    end
`else
                    load      = 1'b1;
                    load_len  = K_FULL;
                    state_nxt = ST_IDLE;
`endif
                    k_nxt = '0;
                end else if (flush_i && k_inc != '0) begin
                    load      = 1'b1;
                    load_len  = k_inc;
`ifdef DESER_PARITY_EN
                    load_par  = 1'b1;
`endif
                    state_nxt = ST_IDLE;
                    k_nxt     = '0;
                end else if (take_bit) begin
                    state_nxt = ST_COLLECT;
                    k_nxt     = k_inc;
                end
            end
        endcase
    end

    // Collector state; the shift register is cleared on every load so partial words are zero-padded.
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            k     <= '0;
            sr    <= '0;
            msb_q <= 1'b1;
        end else begin
            state <= state_nxt;
            k     <= k_nxt;
            sr    <= load ? '0 : sr_next;
            msb_q <= msb_nxt;
        end
    end

    // Output word register with valid/ready; a load while stalled replaces the word and flags overflow.
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            deser_data_o     <= '0;
            deser_len_o      <= '0;
            deser_data_val_o <= 1'b0;
            ovf_o            <= 1'b0;
        end else begin
            ovf_o <= load & deser_data_val_o & ~deser_ready_i;
            if (load) begin
                deser_data_o     <= sr_next;
                deser_len_o      <= load_len;
                deser_data_val_o <= 1'b1;
            end else if (deser_data_val_o && deser_ready_i) begin
                deser_data_val_o <= 1'b0;
            end
        end
    end

`ifdef DESER_PARITY_EN
    // Parity error travels with the word it describes.
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            par_err_o <= 1'b0;
        end else if (load) begin
            par_err_o <= load_par;
        end
    end
`endif

endmodule

// File: tb/tb_deser_param.sv
module tb_deser_param;

    localparam int DATA_W = 16;
    localparam int CNT_W  = 5;

    logic              clk_i = 1'b0;
    logic              arst_n_i;
    logic              data_i;
    logic              data_val_i;
    logic              msb_first_i;
    logic              flush_i;
    logic              deser_ready_i;
    logic [DATA_W-1:0] deser_data_o;
    logic [CNT_W-1:0]  deser_len_o;
    logic              deser_data_val_o;
    logic              ovf_o;
`ifdef DESER_PARITY_EN
    logic              par_err_o;
`endif

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk_i = ~clk_i;

    deser_param #(.DATA_W(DATA_W)) dut (
        .clk_i            (clk_i),
        .arst_n_i         (arst_n_i),
        .data_i           (data_i),
        .data_val_i       (data_val_i),
        .msb_first_i      (msb_first_i),
        .flush_i          (flush_i),
        .deser_ready_i    (deser_ready_i),
        .deser_data_o     (deser_data_o),
        .deser_len_o      (deser_len_o),
        .deser_data_val_o (deser_data_val_o),
        .ovf_o            (ovf_o)
`ifdef DESER_PARITY_EN
        ,
        .par_err_o        (par_err_o)
`endif
    );

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    function automatic logic word_bit(input logic [15:0] w, input logic ord_msb, input int i);
        logic [3:0] idx;
        idx = ord_msb ? 4'(15 - i) : 4'(i);
        return w[idx];
    endfunction

    // One valid bit, preceded by 0..2 random idle cycles.
    task automatic send_bit(input logic b);
        int gap;
        gap = $urandom_range(0, 2);
        data_val_i = 1'b0;
        repeat (gap) tick();
        data_val_i = 1'b1;
        data_i     = b;
        tick();
        data_val_i = 1'b0;
    endtask

    task automatic send_range(input logic [15:0] w, input logic ord_msb, input int from, input int upto);
        for (int i = from; i <= upto; i++) send_bit(word_bit(w, ord_msb, i));
    endtask

    // Last data bit (plus parity when enabled); ready takes final_rdy on the closing edge.
    task automatic send_tail(input logic [15:0] w, input logic ord_msb, input logic final_rdy);
        logic fin;
        int gap;
`ifdef DESER_PARITY_EN
        send_bit(word_bit(w, ord_msb, 15));
        fin = ^w;
`else
        fin = word_bit(w, ord_msb, 15);
`endif
        gap = $urandom_range(0, 2);
        repeat (gap) tick();
        data_val_i    = 1'b1;
        data_i        = fin;
        deser_ready_i = final_rdy;
        tick();
        data_val_i = 1'b0;
    endtask

    task automatic test_reset();
        arst_n_i = 1'b0; data_i = 1'b0; data_val_i = 1'b0; msb_first_i = 1'b1;
        flush_i = 1'b0; deser_ready_i = 1'b1;
        repeat (3) tick();
        n_total++; if (deser_data_o !== 16'h0) $display("FAIL reset_data: got %h want 0000", deser_data_o); else n_pass++;
        n_total++; if (deser_len_o !== 5'd0) $display("FAIL reset_len: got %0d want 0", deser_len_o); else n_pass++;
        n_total++; if (deser_data_val_o !== 1'b0) $display("FAIL reset_vld: got %b want 0", deser_data_val_o); else n_pass++;
        n_total++; if (ovf_o !== 1'b0) $display("FAIL reset_ovf: got %b want 0", ovf_o); else n_pass++;
        arst_n_i = 1'b1;
        repeat (4) tick();
    endtask

    task automatic test_msb_word();
        deser_ready_i = 1'b1; msb_first_i = 1'b1;
        send_range(16'hA5C3, 1'b1, 0, 14);
        n_total++; if (deser_data_val_o !== 1'b0) $display("FAIL msb_early_vld: got %b want 0", deser_data_val_o); else n_pass++;
        send_tail(16'hA5C3, 1'b1, 1'b1);
        n_total++; if (deser_data_val_o !== 1'b1) $display("FAIL msb_vld: got %b want 1", deser_data_val_o); else n_pass++;
        n_total++; if (deser_data_o !== 16'hA5C3) $display("FAIL msb_data: got %h want a5c3", deser_data_o); else n_pass++;
        n_total++; if (deser_len_o !== 5'd16) $display("FAIL msb_len: got %0d want 16", deser_len_o); else n_pass++;
        tick();
        n_total++; if (deser_data_val_o !== 1'b0) $display("FAIL msb_accept: got %b want 0", deser_data_val_o); else n_pass++;
    endtask

    task automatic test_lsb_word();
        deser_ready_i = 1'b1; msb_first_i = 1'b0;
        send_range(16'hA5C3, 1'b0, 0, 14);
        send_tail(16'hA5C3, 1'b0, 1'b1);
        n_total++; if (deser_data_o !== 16'hA5C3 || deser_data_val_o !== 1'b1) $display("FAIL lsb_data: got %h vld %b want a5c3 vld 1", deser_data_o, deser_data_val_o); else n_pass++;
        n_total++; if (deser_len_o !== 5'd16) $display("FAIL lsb_len: got %0d want 16", deser_len_o); else n_pass++;
        tick();
        send_range(16'h1234, 1'b0, 0, 2);
        msb_first_i = 1'b1;
        send_range(16'h1234, 1'b0, 3, 14);
        send_tail(16'h1234, 1'b0, 1'b1);
        n_total++; if (deser_data_o !== 16'h1234 || deser_data_val_o !== 1'b1) $display("FAIL order_hold: got %h vld %b want 1234 vld 1", deser_data_o, deser_data_val_o); else n_pass++;
        tick();
    endtask

    task automatic test_flush();
        logic [4:0] pat;
        pat = 5'b01101;  // bits in send order: 1,0,1,1,0 (pat[0] first)
        deser_ready_i = 1'b1; msb_first_i = 1'b1;
        for (int i = 0; i < 5; i++) send_bit(pat[i]);
        flush_i = 1'b1; tick(); flush_i = 1'b0;
        n_total++; if (deser_data_o !== 16'hB000 || deser_data_val_o !== 1'b1) $display("FAIL flush_msb_data: got %h vld %b want b000 vld 1", deser_data_o, deser_data_val_o); else n_pass++;
        n_total++; if (deser_len_o !== 5'd5) $display("FAIL flush_msb_len: got %0d want 5", deser_len_o); else n_pass++;
`ifdef DESER_PARITY_EN
        n_total++; if (par_err_o !== 1'b1) $display("FAIL flush_par: got %b want 1", par_err_o); else n_pass++;
`endif
        tick();
        msb_first_i = 1'b0;
        for (int i = 0; i < 5; i++) send_bit(pat[i]);
        flush_i = 1'b1; tick(); flush_i = 1'b0;
        n_total++; if (deser_data_o !== 16'h000D || deser_data_val_o !== 1'b1) $display("FAIL flush_lsb_data: got %h vld %b want 000d vld 1", deser_data_o, deser_data_val_o); else n_pass++;
        n_total++; if (deser_len_o !== 5'd5) $display("FAIL flush_lsb_len: got %0d want 5", deser_len_o); else n_pass++;
        tick();
        flush_i = 1'b1; tick(); flush_i = 1'b0;
        n_total++; if (deser_data_val_o !== 1'b0) $display("FAIL flush_empty: got vld %b want 0", deser_data_val_o); else n_pass++;
        msb_first_i = 1'b1;
        for (int i = 0; i < 3; i++) send_bit(1'b1);
        data_val_i = 1'b1; data_i = 1'b1; flush_i = 1'b1; tick();
        data_val_i = 1'b0; flush_i = 1'b0;
        n_total++; if (deser_data_o !== 16'hF000 || deser_len_o !== 5'd4) $display("FAIL flush_same_cycle: got %h len %0d want f000 len 4", deser_data_o, deser_len_o); else n_pass++;
        tick();
    endtask

    task automatic test_overflow();
        deser_ready_i = 1'b0; msb_first_i = 1'b1;
        send_range(16'h1234, 1'b1, 0, 14);
        send_tail(16'h1234, 1'b1, 1'b0);
        n_total++; if (deser_data_o !== 16'h1234 || ovf_o !== 1'b0) $display("FAIL ovf_first: got %h ovf %b want 1234 ovf 0", deser_data_o, ovf_o); else n_pass++;
        send_range(16'hFFFF, 1'b1, 0, 14);
        n_total++; if (deser_data_o !== 16'h1234 || deser_data_val_o !== 1'b1) $display("FAIL ovf_stable: got %h vld %b want 1234 vld 1", deser_data_o, deser_data_val_o); else n_pass++;
        send_tail(16'hFFFF, 1'b1, 1'b0);
        n_total++; if (ovf_o !== 1'b1) $display("FAIL ovf_pulse: got %b want 1", ovf_o); else n_pass++;
        n_total++; if (deser_data_o !== 16'hFFFF) $display("FAIL ovf_data: got %h want ffff", deser_data_o); else n_pass++;
        tick();
        n_total++; if (ovf_o !== 1'b0 || deser_data_val_o !== 1'b1) $display("FAIL ovf_one_cycle: got ovf %b vld %b want ovf 0 vld 1", ovf_o, deser_data_val_o); else n_pass++;
        deser_ready_i = 1'b1;
        tick();
        n_total++; if (deser_data_val_o !== 1'b0) $display("FAIL ovf_drain: got vld %b want 0", deser_data_val_o); else n_pass++;
    endtask

    task automatic test_back_to_back();
        deser_ready_i = 1'b0; msb_first_i = 1'b1;
        send_range(16'h00FF, 1'b1, 0, 14);
        send_tail(16'h00FF, 1'b1, 1'b0);
        send_range(16'h5A5A, 1'b1, 0, 14);
        send_tail(16'h5A5A, 1'b1, 1'b1);
        n_total++; if (deser_data_val_o !== 1'b1 || deser_data_o !== 16'h5A5A) $display("FAIL b2b_data: got %h vld %b want 5a5a vld 1", deser_data_o, deser_data_val_o); else n_pass++;
        n_total++; if (ovf_o !== 1'b0) $display("FAIL b2b_ovf: got %b want 0", ovf_o); else n_pass++;
        tick();
        n_total++; if (deser_data_val_o !== 1'b0) $display("FAIL b2b_drain: got vld %b want 0", deser_data_val_o); else n_pass++;
    endtask

    task automatic test_reset_mid();
        deser_ready_i = 1'b1; msb_first_i = 1'b1;
        send_range(16'hFFFF, 1'b1, 0, 8);
        arst_n_i = 1'b0;
        #2;
        n_total++; if (deser_data_o !== 16'h0 || deser_len_o !== 5'd0) $display("FAIL rst_mid_out: got %h len %0d want 0000 len 0", deser_data_o, deser_len_o); else n_pass++;
        n_total++; if (deser_data_val_o !== 1'b0 || ovf_o !== 1'b0) $display("FAIL rst_mid_flags: got vld %b ovf %b want 0 0", deser_data_val_o, ovf_o); else n_pass++;
        tick(); tick();
        arst_n_i = 1'b1;
        repeat (4) tick();
        send_range(16'h0F0F, 1'b1, 0, 14);
        send_tail(16'h0F0F, 1'b1, 1'b1);
        n_total++; if (deser_data_o !== 16'h0F0F || deser_data_val_o !== 1'b1) $display("FAIL rst_mid_word: got %h vld %b want 0f0f vld 1", deser_data_o, deser_data_val_o); else n_pass++;
        n_total++; if (deser_len_o !== 5'd16) $display("FAIL rst_mid_len: got %0d want 16", deser_len_o); else n_pass++;
        tick();
    endtask

`ifdef DESER_PARITY_EN
    task automatic test_parity();
        deser_ready_i = 1'b1; msb_first_i = 1'b1;
        send_range(16'h0001, 1'b1, 0, 15);
        n_total++; if (deser_data_val_o !== 1'b0) $display("FAIL par_wait: got vld %b want 0", deser_data_val_o); else n_pass++;
        send_bit(1'b1);
        n_total++; if (deser_data_o !== 16'h0001 || deser_data_val_o !== 1'b1) $display("FAIL par_data: got %h vld %b want 0001 vld 1", deser_data_o, deser_data_val_o); else n_pass++;
        n_total++; if (par_err_o !== 1'b0) $display("FAIL par_ok: got %b want 0", par_err_o); else n_pass++;
        tick();
        send_range(16'h0001, 1'b1, 0, 15);
        send_bit(1'b0);
        n_total++; if (par_err_o !== 1'b1 || deser_data_o !== 16'h0001) $display("FAIL par_bad: got err %b data %h want 1 0001", par_err_o, deser_data_o); else n_pass++;
        tick();
    endtask
`endif

    initial begin
        test_reset();
        test_msb_word();
        test_lsb_word();
        test_flush();
        test_overflow();
        test_back_to_back();
        test_reset_mid();
`ifdef DESER_PARITY_EN
        test_parity();
`endif
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/deser_param.md
Name: deser_param

Overview:
- Parametrised successor of the team's fixed 16-bit deserializer. It collects a serial bit stream qualified by data_val_i into DATA_W-bit words.
- Bit order (MSB-first or LSB-first) is selectable per word.
- A flush request emits a partial word together with its bit count.
- The output is a registered word with a valid/ready handshake and an overflow flag. It sits between a serial link front-end and a parallel consumer.

Parameters:
- DATA_W, 16, word width in bits; legal range 2..64.
- CNT_W, $clog2(DATA_W+1), width of the bit counter and of deser_len_o; derived, do not override.

Ports:
- clk_i  in  1  clock; all logic on rising edge.
- arst_n_i  in  1  asynchronous active-low reset.
- data_i  in  1  serial data bit.
- data_val_i  in  1  data_i is valid this cycle.
- msb_first_i  in  1  1 = first received bit lands in bit DATA_W-1; 0 = first bit lands in bit 0. Sampled with the first valid bit of each word and held for that word.
- flush_i  in  1  single-cycle pulse: emit the bits collected so far.
- deser_ready_i  in  1  consumer accepts the word when deser_data_val_o=1.
- deser_data_o  out  DATA_W  deserialized word.
- deser_len_o  out  CNT_W  number of valid bits in deser_data_o (1..DATA_W).
- deser_data_val_o  out  1  output word valid; held until accepted.
- ovf_o  out  1  one-cycle pulse: a pending unaccepted word was overwritten.

Behaviour:
- Reset (arst_n_i=0, async assert, sync deassert internally):
  - all outputs 0;
  - bit counter 0, shift register 0, latched order = MSB-first.
  - Reset mid-word discards the partial word; no output is produced.
- Counter k (0..DATA_W-1), states:
  - IDLE: k=0. A valid bit latches msb_first_i, stores the bit, sets k=1 and moves to COLLECT.
  - COLLECT: each valid bit stores at position (msb ? DATA_W-1-k : k) and increments k.
  - Word completion: the bit that makes k reach DATA_W completes the word. k returns to 0, state returns to IDLE.
- Completion/load timing:
  - On the same clock edge that samples the completing bit, the word is loaded into deser_data_o with deser_len_o=DATA_W, and deser_data_val_o=1 from that edge.
  - Latency: last valid bit to valid output is 1 edge.
- Flush:
  - flush_i=1 with k>0 (including a valid bit in the same cycle, which is counted first) loads a partial word with len = k(+1).
  - MSB-first: bits in [DATA_W-1 : DATA_W-len]; LSB-first: bits in [len-1 : 0]; unused bits 0.
  - The collector then returns to IDLE.
  - flush_i with k=0 and no valid bit: no effect.
  - If the same-cycle bit completes the word, the result is a normal full word (len=DATA_W); no additional empty word is emitted.
- Handshake:
  - A transfer occurs on an edge with deser_data_val_o & deser_ready_i.
  - On transfer, deser_data_val_o clears, unless a new word loads on the same edge; then it stays 1 with the new data and len, and ovf_o stays 0.
  - deser_data_o and deser_len_o are stable while valid=1 and not accepted.
  - After a transfer they hold their last value; the bench checks them only when valid=1.
- Overflow:
  - The input cannot be stalled. If a new word loads while valid=1 and deser_ready_i=0, the new word replaces the old one and ovf_o pulses 1 for one cycle.
- Order changes: msb_first_i changing mid-word has no effect until the next word.

Optional Feature:
- Macro DESER_PARITY_EN.
- When defined:
  - Adds output port par_err_o (1 bit) and state PARITY.
  - After DATA_W data bits, the collector enters PARITY and the next valid bit is an even-parity bit over the data.
  - The word loads on the parity bit's edge (latency = DATA_W+1 valid bits). par_err_o = XOR(data bits, parity bit), aligned with and held like deser_data_o.
  - Flush in PARITY loads the word with len=DATA_W and par_err_o=1.
  - Partial flushed words carry par_err_o=1.
  - par_err_o resets to 0.
- When not defined: no PARITY state, no par_err_o port; behaviour exactly as above.

Test Plan:
- Reset, then 16 bits of 0xA5C3 MSB-first, data_val_i toggled randomly, ready=1 -> deser_data_val_o rises 1 edge after the 16th valid bit; data=0xA5C3, len=16; valid=0 beforehand.
- msb_first_i=0, bits of 0xA5C3 sent LSB-first -> data=0xA5C3, len=16; then msb_first_i toggled after 3 bits of the next word -> that word is still assembled LSB-first.
- 5 bits 1,0,1,1,0 MSB-first, then flush_i -> data=0xB000, len=5. Same bits LSB-first + flush -> data=0x000D, len=5. Flush with k=0 -> no valid.
- ready=0, two full words 0x1234 then 0xFFFF -> ovf_o pulses once when the second word loads, data=0xFFFF. Raise ready -> one transfer, then valid=0.
- Assert arst_n_i low after 9 bits, release, send 0x0F0F -> all outputs 0 during reset; output 0x0F0F with len=16, no stale bits.
- DESER_PARITY_EN defined: 0x0001 + parity 1 -> par_err_o=0; 0x0001 + parity 0 -> par_err_o=1; word valid only after the parity bit.
